machine_monitor: RTL and testbench

//   Downstream observer of the 3-bit JK state machine. Samples its state bus S and

---
 rtl/machine_monitor.sv | 83 ++++++++
 tb/tb_machine_monitor.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/machine_monitor.sv
// Transition logger + F counter for the 3-bit JK machine; optional MONITOR_SATURATE_EN saturates f_count.
// Latency: a record is visible one edge after S changes. Backpressure: FWFT valid/ready; full drops + sticky overflow.
module machine_monitor #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       F,
    input  logic [2:0]                 S,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [5:0]                 rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           f_count,
    output logic                       overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [2:0]       s_prev;
    logic [5:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             evt;
    logic             full;
    logic             push;
    logic             pop;

    assign evt      = (S != s_prev);
    assign full     = (level == LVL_W'(DEPTH));
    assign rd_valid = (level != '0);
    assign pop      = rd_valid && rd_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign push     = evt && (!full || pop);
    assign rd_data  = rd_valid ? mem[rd_ptr] : 6'h00;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {s_prev, S};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s_prev   <= 3'b000;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            s_prev <= S;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
            if (evt && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            f_count <= '0;
        end else if (F) begin
`ifdef MONITOR_SATURATE_EN
            if (f_count != '1) begin
                f_count <= f_count + CNT_W'(1);
            end
`else
            f_count <= f_count + CNT_W'(1);
`endif
        end
    end
endmodule

// File: tb/tb_machine_monitor.sv
// Directed bench for machine_monitor with hand-computed records, levels and counts.
module tb_machine_monitor;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       F;
    logic [2:0] S;
    logic       rd_ready;
    logic       rd_valid;
    logic [5:0] rd_data;
    logic [2:0] level;
    logic [7:0] f_count;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    machine_monitor #(.DEPTH(4), .CNT_W(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .F        (F),
        .S        (S),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .level    (level),
        .f_count  (f_count),
        .overflow (overflow)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        RESET = 1'b1; F = 1'b0; S = 3'b000; rd_ready = 1'b0;
        // 1: reset state, then idle S produces nothing
        tick(); tick();
        chk("rst_valid", rd_valid, 0);
        chk("rst_data",  rd_data,  0);
        chk("rst_level", level,    0);
        chk("rst_fcnt",  f_count,  0);
        chk("rst_ovf",   overflow, 0);
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("idle_valid", rd_valid, 0);
        chk("idle_level", level,    0);

        // 2: 000->011->011->110
        S = 3'b011; tick();
        chk("t2_lvl1",  level,   1);
        chk("t2_data1", rd_data, 6'h03);
        tick();
        chk("t2_hold",  level,   1);
        S = 3'b110; tick();
        chk("t2_lvl2",  level,   2);
        chk("t2_stable", rd_data, 6'h03);
        rd_ready = 1'b1; tick();
        chk("t2_pop_lvl",  level,   1);
        chk("t2_pop_data", rd_data, 6'h1E);
        tick();
        chk("t2_empty_valid", rd_valid, 0);
        chk("t2_empty_data",  rd_data,  0);
        tick();
        chk("t2_rdy_empty", level, 0);
        rd_ready = 1'b0;

        // 4: fill, then push+pop on a full FIFO
        S = 3'b001; tick();
        S = 3'b010; tick();
        S = 3'b011; tick();
        S = 3'b100; tick();
        chk("t4_full_lvl", level,    4);
        chk("t4_full_ovf", overflow, 0);
        chk("t4_head",     rd_data,  6'h31);
        rd_ready = 1'b1; S = 3'b101; tick();
        chk("t4_pp_lvl",  level,    4);
        chk("t4_pp_ovf",  overflow, 0);
        chk("t4_pp_head", rd_data,  6'h0A);
        tick(); chk("t4_d1", rd_data, 6'h13);
        tick(); chk("t4_d2", rd_data, 6'h1C);
        tick(); chk("t4_tail", rd_data, 6'h25);
        chk("t4_tail_lvl", level, 1);
        tick(); chk("t4_drained", level, 0);
        rd_ready = 1'b0;

        // 3: five transitions into a 4-deep FIFO
        S = 3'b110; tick();
        S = 3'b111; tick();
        S = 3'b000; tick();
        S = 3'b001; tick();
        chk("t3_no_ovf_yet", overflow, 0);
        S = 3'b010; tick();
        chk("t3_lvl",  level,    4);
        chk("t3_ovf",  overflow, 1);
        chk("t3_head", rd_data,  6'h2E);
        tick();
        chk("t3_sticky", overflow, 1);

        // 6: reset at level 3 with overflow set
        rd_ready = 1'b1; tick();
        rd_ready = 1'b0;
        chk("t6_pre_lvl",  level,    3);
        chk("t6_pre_head", rd_data,  6'h37);
        chk("t6_pre_ovf",  overflow, 1);
        RESET = 1'b1; rd_ready = 1'b1; S = 3'b000; tick();
        chk("t6_lvl",   level,    0);
        chk("t6_valid", rd_valid, 0);
        chk("t6_ovf",   overflow, 0);
        chk("t6_data",  rd_data,  0);
        RESET = 1'b0; rd_ready = 1'b0; tick();
        chk("t6_sprev", level, 0);

        // 5: f_count over 257 edges
        F = 1'b1;
        for (int i = 0; i < 257; i++) begin
            tick();
            if (i == 254) chk("t5_255", f_count, 8'd255);
        end
`ifdef MONITOR_SATURATE_EN
        chk("t5_final", f_count, 8'd255);
`else
        chk("t5_final", f_count, 8'd1);
`endif
        F = 1'b0; tick();
`ifdef MONITOR_SATURATE_EN
        chk("t5_hold", f_count, 8'd255);
`else
        chk("t5_hold", f_count, 8'd1);
`endif
        chk("t5_no_rec", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
